// File: rtl/fork2.sv
// Four-phase handshake fork: one upstream request is split into two downstream
// requests, and upstream is acknowledged once both branches have acknowledged.
module fork2 #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_in_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ack_in_o,
    output logic              req_out1_o,
    output logic              req_out2_o,
    input  logic              ack_out1_i,
    input  logic              ack_out2_i,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACKD,
        RELEASE
    } state_t;

    state_t              state_q;
    logic                done1_q;
    logic                done2_q;
    logic                req_out_q;
    logic                ack_in_q;
    logic                err_q;
    logic [DATA_W-1:0]   data_q;

    logic                req_s;
    logic                ack1_s;
    logic                ack2_s;
    logic                done1_now;
    logic                done2_now;
    logic                err_hit;

    // Bundle {req, ack1, ack2} through a common synchronizer chain.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign {req_s, ack1_s, ack2_s} = {req_in_i, ack_out1_i, ack_out2_i};
        end else begin : g_sync
            logic [2:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= 3'b000;
                    end
                end else begin
                    sync_q[0] <= {req_in_i, ack_out1_i, ack_out2_i};
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign {req_s, ack1_s, ack2_s} = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign done1_now = done1_q | ack1_s;
    assign done2_now = done2_q | ack2_s;

    // A branch dropping its ack after it was counted is a protocol violation.
    assign err_hit = ((state_q == IDLE) && (ack1_s || ack2_s)) ||
                     ((state_q == REQ)  && (!req_s ||
                                            (done1_q && !ack1_s) ||
                                            (done2_q && !ack2_s)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            done1_q   <= 1'b0;
            done2_q   <= 1'b0;
            req_out_q <= 1'b0;
            ack_in_q  <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            err_q <= err_q | err_hit;
            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        data_q    <= data_i;
                        req_out_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    done1_q <= done1_now;
                    done2_q <= done2_now;
                    if (done1_now && done2_now) begin
                        ack_in_q <= 1'b1;
                        state_q  <= ACKD;
                    end
                end
                ACKD: begin
                    if (!req_s) begin
                        req_out_q <= 1'b0;
                        state_q   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack1_s && !ack2_s) begin
                        done1_q  <= 1'b0;
                        done2_q  <= 1'b0;
                        ack_in_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_out1_o = req_out_q;
    assign req_out2_o = req_out_q;
    assign ack_in_o   = ack_in_q;
    assign err_o      = err_q;
    assign data_o     = data_q;

endmodule

// File: doc/fork2.md
FORK2 -- requirements
Module: fork2

Interface
REQ-001 Parameter DATA_W, default 32, bundled-data width in bits (legal 1..256).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops on each of req_in_i, ack_out1_i and ack_out2_i (legal 0..3; 0 = sampled directly).
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 req_in_i  in  1  upstream four-phase request.
REQ-006 data_i  in  DATA_W  upstream bundled data, valid while req_in_i high.
REQ-007 ack_in_o  out  1  upstream acknowledge.
REQ-008 req_out1_o / req_out2_o  out  1 each  downstream requests, branch 1 / branch 2.
REQ-009 ack_out1_i / ack_out2_i  in  1 each  downstream acknowledges.
REQ-010 data_o  out  DATA_W  captured data, common to both branches.
REQ-011 err_o  out  1  sticky protocol-violation flag.

Function
REQ-012 All outputs SHALL be driven directly from flops; no combinational input-to-output path.
REQ-013 States SHALL be IDLE, REQ, ACKD and RELEASE; below, "req", "ack1" and "ack2" are the post-synchronizer values.
REQ-014 IDLE: req_out1_o=req_out2_o=0 and ack_in_o=0; on req=1, capture data_i into data_o and go to REQ.
REQ-015 REQ: req_out1_o=req_out2_o=1; per-branch flags done1/done2 set on ack1/ack2 high; when both flags set (or set this cycle) go to ACKD.
REQ-016 ACKD: ack_in_o=1, requests held high; on req=0 go to RELEASE.
REQ-017 RELEASE: req_out1_o=req_out2_o=0, ack_in_o held 1; when ack1=0 and ack2=0 clear done1/done2, drive ack_in_o=0 and go to IDLE.
REQ-018 Latency: req_in_i sampled high at edge k SHALL make req_out1_o/req_out2_o high after edge k+SYNC_STAGES; each subsequent transition also takes exactly one cycle after the enabling condition is sampled.
REQ-019 data_o SHALL remain stable from the IDLE->REQ edge until the next IDLE->REQ edge; data_i changes in any other state SHALL be ignored.
REQ-020 Acks arriving in different cycles SHALL both be remembered; ACKD is entered only once both have been seen.
REQ-021 Both acks rising in the same cycle SHALL move REQ->ACKD in one cycle.
REQ-022 A new req while in RELEASE SHALL NOT be accepted until IDLE has been reached and req is sampled again.
REQ-023 err_o SHALL set and stay set on any of: ack1 or ack2 high in IDLE; req falling in REQ; ack1 or ack2 falling in REQ after its done flag is set. FSM behaviour is unchanged by err_o.

Reset
REQ-024 With rst_i high at an edge, state SHALL become IDLE; ack_in_o, req_out1_o, req_out2_o and err_o SHALL be 0; done flags, synchronizer flops and data_o SHALL be 0.
REQ-025 Reset asserted mid-handshake (any state) SHALL take effect at that edge and override all other transitions.
REQ-026 After reset deassertion, a req_in_i still held high SHALL start a fresh handshake after the synchronizer latency.

Verification
REQ-027 SYNC_STAGES=0, data_i=0xA5A5_0001, req_in_i=1 at edge 0 -> req_out1_o=req_out2_o=1 and data_o=0xA5A5_0001 after edge 0; both acks at edge 3 -> ack_in_o=1 after edge 3.
REQ-028 ack_out1_i pulses high at edge 2 and stays high; ack_out2_i rises at edge 6 -> ack_in_o stays 0 until edge 6, then rises after edge 6; err_o=0.
REQ-029 Full four-phase cycle: req_in_i falls in ACKD -> requests drop next cycle; ack_in_o stays 1 until both acks are low, then falls; state back to IDLE; repeated 100 random-delay handshakes complete with err_o=0.
REQ-030 ack_out2_i=1 while IDLE -> err_o=1 after one cycle (plus SYNC_STAGES); err_o stays 1 until rst_i.
REQ-031 rst_i=1 while in ACKD -> after that edge all outputs 0; with req_in_i held 1, a new handshake starts SYNC_STAGES+1 edges after rst_i falls.
REQ-032 SYNC_STAGES=2: req_in_i rises at edge 0 -> req_out1_o rises after edge 2; data_i changed at edge 3 -> data_o unchanged.
